// File: rtl/col_psum_accum.sv
// rtl/col_psum_accum.sv - row partial-sum scatter-add accumulator with streaming drain
module col_psum_accum #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int NO_PIX_ROW    = 8,
    parameter int ACC_WIDTH     = 20,
    localparam int OUT_LEN      = NO_PIX_ROW + NO_COL_KERNEL - 1,
    localparam int PIX_W        = (NO_PIX_ROW > 1) ? $clog2(NO_PIX_ROW) : 1,
    localparam int IDX_W        = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0]   i_feature_map_col,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    output logic [ACC_WIDTH-1:0]                   o_psum,
    output logic                                   o_psum_valid,
    input  logic                                   i_psum_ready,
    output logic                                   o_row_done,
    output logic [PIX_W-1:0]                       o_pix_cnt
);

    typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q [OUT_LEN];
    logic [ACC_WIDTH-1:0]   acc_d [OUT_LEN];
    logic [ACC_WIDTH-1:0]   prod_ext [NO_COL_KERNEL];
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]       drain_idx_q, drain_idx_d;
    logic                   row_done_q, row_done_d;
    logic                   accept, drain_fire, last_pix, last_elem;

    assign accept     = (state_q == ST_ACCUM) && i_valid;
    assign drain_fire = (state_q == ST_DRAIN) && i_psum_ready;
    assign last_pix   = (pix_cnt_q == PIX_W'(NO_PIX_ROW - 1));
    assign last_elem  = (drain_idx_q == IDX_W'(OUT_LEN - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_ACCUM;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && last_pix)     state_d = ST_DRAIN;
            ST_DRAIN: if (drain_fire && last_elem) state_d = ST_ACCUM;
            default:                               state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        o_ready      = (state_q == ST_ACCUM);
        o_psum_valid = (state_q == ST_DRAIN);
        o_psum       = '0;
        if (state_q == ST_DRAIN) begin
            for (int i = 0; i < OUT_LEN; i++)
                if (drain_idx_q == IDX_W'(i)) o_psum = acc_q[i];
        end
        o_row_done   = row_done_q;
        o_pix_cnt    = pix_cnt_q;
    end

    always_comb begin
        for (int k = 0; k < NO_COL_KERNEL; k++)
            prod_ext[k] = ACC_WIDTH'($signed(i_feature_map_col[2*k*BIT_WIDTH +: 2*BIT_WIDTH]));
    end

    // Each entry receives at most one lane per beat, and is cleared as it drains.
    always_comb begin
        for (int j = 0; j < OUT_LEN; j++) begin
            acc_d[j] = acc_q[j];
            if (accept) begin
                for (int k = 0; k < NO_COL_KERNEL; k++)
                    if (int'(pix_cnt_q) + k == j) acc_d[j] = acc_q[j] + prod_ext[k];
            end
            if (drain_fire && drain_idx_q == IDX_W'(j)) acc_d[j] = '0;
        end
    end

    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        drain_idx_d = drain_idx_q;
        row_done_d  = drain_fire && last_elem;
        if (accept)     pix_cnt_d   = last_pix  ? '0 : pix_cnt_q + 1'b1;
        if (drain_fire) drain_idx_d = last_elem ? '0 : drain_idx_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < OUT_LEN; j++) acc_q[j] <= '0;
            pix_cnt_q   <= '0;
            drain_idx_q <= '0;
            row_done_q  <= 1'b0;
        end else begin
            for (int j = 0; j < OUT_LEN; j++) acc_q[j] <= acc_d[j];
            pix_cnt_q   <= pix_cnt_d;
            drain_idx_q <= drain_idx_d;
            row_done_q  <= row_done_d;
        end
    end

endmodule

// File: tb/tb_col_psum_accum.sv
// tb/tb_col_psum_accum.sv - randomized self-checking bench for col_psum_accum
module tb_col_psum_accum;

    localparam int BW = 8;
    localparam int NK = 5;
    localparam int NP = 8;
    localparam int AW = 20;
    localparam int OL = NP + NK - 1;
    localparam int PW = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [2*BW*NK-1:0]     fmap;
    logic                   valid, psum_ready;
    logic                   ready_a, pvalid_a, done_a;
    logic                   ready_b, pvalid_b, done_b;
    logic [AW-1:0]          psum_a;
    logic [15:0]            psum_b;
    logic [PW-1:0]          pix_a, pix_b;

    always #5 clk = ~clk;

    col_psum_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .NO_PIX_ROW(NP), .ACC_WIDTH(AW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_feature_map_col(fmap), .i_valid(valid),
        .o_ready(ready_a), .o_psum(psum_a), .o_psum_valid(pvalid_a),
        .i_psum_ready(psum_ready), .o_row_done(done_a), .o_pix_cnt(pix_a)
    );

    col_psum_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .NO_PIX_ROW(NP), .ACC_WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_feature_map_col(fmap), .i_valid(valid),
        .o_ready(ready_b), .o_psum(psum_b), .o_psum_valid(pvalid_b),
        .i_psum_ready(psum_ready), .o_row_done(done_b), .o_pix_cnt(pix_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] beats [NP][NK];
    longint      exp_row [OL];
    logic [31:0] got20 [OL];
    logic [31:0] got16 [OL];
    bit          pending_done = 1'b0;
    int          ones_tab [OL] = '{1, 2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wrap_to(input longint v, input int w);
        return 32'(v & ((longint'(1) << w) - 1));
    endfunction

    task automatic fill(input bit rnd, input logic [15:0] c);
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < NK; k++)
                beats[p][k] = rnd ? 16'($urandom) : c;
        // Scatter-add reference: pixel p, lane k lands in output p+k.
        for (int j = 0; j < OL; j++) exp_row[j] = 0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < NK; k++)
                exp_row[p+k] += longint'($signed(beats[p][k]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {ready_b, ready_a},   2'b11);
        check({tag, "_pvalid"}, {pvalid_b, pvalid_a}, 2'b00);
        check({tag, "_psum"},   psum_a,               0);
        check({tag, "_psum16"}, psum_b,               0);
        check({tag, "_done"},   {done_b, done_a},     2'b00);
        check({tag, "_pix"},    pix_a,                0);
    endtask

    task automatic run_row(input bit gaps, input bit bp, input int abort_after, output int period);
        int p = 0, idx = 0, cyc = 0, first = -1;
        period = -1;
        while (p < NP) begin
            @(negedge clk);
            if (cyc > 1000) begin
                check("accum_timeout", 0, 1);
                return;
            end
            check("ready_accum", ready_a, 1);
            check("pvalid_accum", pvalid_a, 0);
            check("pix_cnt", pix_a, p);
            check("row_done_accum", {done_b, done_a}, {2{pending_done}});
            pending_done = 1'b0;
            valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int k = 0; k < NK; k++) fmap[16*k +: 16] = beats[p][k];
            @(posedge clk);
            if (valid) begin
                if (first < 0) first = cyc;
                p++;
            end
            cyc++;
        end
        while (idx < OL) begin
            @(negedge clk);
            if (cyc > 2000) begin
                check("drain_timeout", 0, 1);
                return;
            end
            check("ready_drain", {ready_b, ready_a}, 2'b00);
            check("pvalid_drain", {pvalid_b, pvalid_a}, 2'b11);
            check("row_done_drain", {done_b, done_a}, 2'b00);
            check("psum20", psum_a, wrap_to(exp_row[idx], AW));
            check("psum16", psum_b, wrap_to(exp_row[idx], 16));
            got20[idx] = 32'(psum_a);
            got16[idx] = 32'(psum_b);
            if (idx == abort_after) begin
                rst_n = 1'b0;
                valid = 1'b0;
                psum_ready = 1'b0;
                #1;
                check_reset_outputs("mid_drain_rst");
                @(negedge clk);
                rst_n = 1'b1;
                pending_done = 1'b0;
                return;
            end
            // Inputs during drain must be ignored, so drive junk on them.
            valid = 1'($urandom_range(0, 1));
            fmap = {$urandom, $urandom, $urandom};
            psum_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            if (psum_ready) idx++;
            cyc++;
        end
        #1;
        valid = 1'b0;
        pending_done = 1'b1;
        period = cyc - first;
    endtask

    task automatic check_ones(input string tag);
        for (int j = 0; j < OL; j++) check(tag, got20[j], 32'(ones_tab[j]));
    endtask

    initial begin
        int per;
        rst_n = 1'b0;
        valid = 1'b0;
        psum_ready = 1'b0;
        fmap = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fill(1'b0, 16'd1);
        run_row(1'b0, 1'b0, -1, per);
        check_ones("all_ones");
        check("row_period", per, NP + OL);

        fill(1'b0, 16'hFFFF);
        run_row(1'b0, 1'b0, -1, per);
        check("sext_first", got20[0], 32'hFFFFF);
        check("sext_mid", got20[5], 32'hFFFFB);
        check("sext_last", got20[OL-1], 32'hFFFFF);

        fill(1'b0, 16'd1);
        run_row(1'b1, 1'b1, -1, per);
        check_ones("gaps_bp");

        fill(1'b0, 16'd2);
        run_row(1'b0, 1'b0, -1, per);
        check("twos_pos4", got20[4], 10);
        check("twos_pos11", got20[11], 2);
        fill(1'b0, 16'd1);
        run_row(1'b0, 1'b0, -1, per);
        check_ones("after_twos");

        fill(1'b0, 16'd1);
        run_row(1'b0, 1'b0, 3, per);
        fill(1'b0, 16'd1);
        run_row(1'b0, 1'b0, -1, per);
        check_ones("after_reset");

        fill(1'b0, 16'h7FFF);
        run_row(1'b0, 1'b0, -1, per);
        check("wrap16_pos4", got16[4], 32'h7FFB);
        check("wide_pos4", got20[4], 32'h27FFB);

        for (int r = 0; r < 20; r++) begin
            fill(1'b1, 16'd0);
            run_row(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, per);
        end

        @(negedge clk);
        check("final_row_done", {done_b, done_a}, {2{pending_done}});
        check("final_ready", ready_a, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
